// File: rtl/lc4_xm_stage.sv
// LC4 execute-to-memory pipeline register.
// Captures the ALU result and control fields, owns the architectural NZP and
// multi-word shift carry flags, and resolves branches/jumps/traps into a
// registered redirect for fetch.
module lc4_xm_stage #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  input  logic [15:0]          i_insn,
  input  logic [15:0]          i_pc,
  input  logic [WORD_SIZE-1:0] i_alu_result,
  input  logic [WORD_SIZE-1:0] i_r1data,
  input  logic [WORD_SIZE-1:0] i_r2data,
  input  logic [2:0]           i_wsel,
  input  logic                 i_we,
  input  logic                 i_stall,
  input  logic                 i_flush,
  output logic                 o_ready,
  output logic                 o_carry,
  output logic                 o_valid,
  output logic [15:0]          o_insn,
  output logic [15:0]          o_pc,
  output logic [WORD_SIZE-1:0] o_result,
  output logic [2:0]           o_wsel,
  output logic                 o_we,
  output logic [2:0]           o_nzp,
  output logic                 o_redirect,
  output logic [15:0]          o_target
);

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ARI  = 4'b0001;
  localparam logic [3:0] OP_CMP  = 4'b0010;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_SHF  = 4'b1010;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [2:0] NZP_RST = 3'b010;

  // Payload that travels with the instruction into the memory stage.
  typedef struct packed {
    logic [15:0]          insn;
    logic [15:0]          pc;
    logic [WORD_SIZE-1:0] result;
    logic [2:0]           wsel;
  } xm_data_t;

  xm_data_t   req, xm;
  logic       accept;
  logic [3:0] opcode;
  logic       is_cmp, is_br, is_xfer, is_sdr1, is_sdr2;
  logic       taken, nzp_upd;
  logic [2:0] nzp_new;
  logic       res_neg, res_zero;

  // Only bit 0 of each operand feeds the carry flag; the rest is intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{i_r1data[WORD_SIZE-1:1], i_r2data[WORD_SIZE-1:1]};

  assign o_ready = ~i_stall;
  // Flush wins over stall, so an accept needs both quiet.
  assign accept  = i_valid & ~i_stall & ~i_flush;

  assign req = '{insn: i_insn, pc: i_pc, result: i_alu_result, wsel: i_wsel};

  // Decode the few instruction classes this stage cares about.
  always_comb begin
    opcode  = i_insn[15:12];
    is_cmp  = (opcode == OP_CMP);
    is_br   = (opcode == OP_BR);
    is_xfer = (opcode == OP_JSR) || (opcode == OP_JMP) ||
              (opcode == OP_TRAP) || (opcode == OP_RTI);
    is_sdr1 = (opcode == OP_ARI) && (i_insn[5:3] == 3'b011);
    is_sdr2 = (opcode == OP_SHF) && (i_insn[5:4] == 2'b11);
  end

  // Branch resolution uses the flags left by older instructions (o_nzp before this edge).
  always_comb begin
    taken = 1'b0;
    if (is_br)   taken = |(i_insn[11:9] & o_nzp);
    if (is_xfer) taken = 1'b1;
  end

  // New NZP from the ALU result; exactly one bit is set by construction.
  always_comb begin
    res_neg  = i_alu_result[WORD_SIZE-1];
    res_zero = (i_alu_result == '0);
    nzp_new  = {res_neg, res_zero, ~res_neg & ~res_zero};
    nzp_upd  = i_we | is_cmp;
  end

  // Control bits: cleared on flush or bubble, held on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid    <= 1'b0;
      o_we       <= 1'b0;
      o_redirect <= 1'b0;
    end else if (i_flush) begin
      o_valid    <= 1'b0;
      o_we       <= 1'b0;
      o_redirect <= 1'b0;
    end else if (!i_stall) begin
      o_valid    <= i_valid;
      o_we       <= i_valid & i_we;
      o_redirect <= i_valid & taken;
    end
  end

  // Data payload loads only on accept; otherwise it is simply held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      xm <= '0;
    else if (accept) xm <= req;
  end

  // Architectural NZP: register writers and CMP update it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                o_nzp <= NZP_RST;
    else if (accept & nzp_upd) o_nzp <= nzp_new;
  end

  // Shift carry: SDR1 seeds it, SDR2 consumes the old value and reloads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                o_carry <= 1'b0;
    else if (accept & is_sdr1) o_carry <= i_r1data[0];
    else if (accept & is_sdr2) o_carry <= i_r2data[0];
  end

  // Redirect target: ALU already produced the destination; hold when not taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              o_target <= '0;
    else if (accept & taken) o_target <= i_alu_result[15:0];
  end

  assign o_insn   = xm.insn;
  assign o_pc     = xm.pc;
  assign o_result = xm.result;
  assign o_wsel   = xm.wsel;

endmodule

// File: tb/tb_lc4_xm_stage.sv
// Self-checking bench for lc4_xm_stage: directed scenarios plus randomized
// traffic compared against an architectural model of the stage.
module tb_lc4_xm_stage;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid, i_we, i_stall, i_flush;
  logic [15:0]   i_insn, i_pc;
  logic [W-1:0]  i_alu_result, i_r1data, i_r2data;
  logic [2:0]    i_wsel;
  logic          o_ready, o_carry, o_valid, o_we, o_redirect;
  logic [15:0]   o_insn, o_pc, o_target;
  logic [W-1:0]  o_result;
  logic [2:0]    o_wsel, o_nzp;

  lc4_xm_stage #(.WORD_SIZE(W)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_insn(i_insn), .i_pc(i_pc),
    .i_alu_result(i_alu_result), .i_r1data(i_r1data), .i_r2data(i_r2data),
    .i_wsel(i_wsel), .i_we(i_we), .i_stall(i_stall), .i_flush(i_flush),
    .o_ready(o_ready), .o_carry(o_carry), .o_valid(o_valid), .o_insn(o_insn),
    .o_pc(o_pc), .o_result(o_result), .o_wsel(o_wsel), .o_we(o_we),
    .o_nzp(o_nzp), .o_redirect(o_redirect), .o_target(o_target)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: what the memory stage should be holding.
  logic         m_valid, m_we, m_redir, m_carry;
  logic [2:0]   m_nzp;
  logic [15:0]  m_insn, m_pc, m_tgt;
  logic [W-1:0] m_res;
  logic [2:0]   m_wsel;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_valid = 0; m_we = 0; m_redir = 0; m_carry = 0; m_nzp = 3'b010;
    m_insn = 0; m_pc = 0; m_tgt = 0; m_res = 0; m_wsel = 0;
  endfunction

  // Apply one clock edge of architectural behaviour to the model.
  function automatic void model_edge();
    int  op;
    bit  tk;
    op = int'(i_insn[15:12]);
    if (i_flush) begin
      m_valid = 0; m_we = 0; m_redir = 0;
    end else if (i_stall) begin
      // everything holds
    end else if (!i_valid) begin
      m_valid = 0; m_we = 0; m_redir = 0;
    end else begin
      case (op)
        0:             tk = (i_insn[11] && m_nzp[2]) || (i_insn[10] && m_nzp[1]) ||
                            (i_insn[9] && m_nzp[0]);
        4, 12, 15, 8:  tk = 1;
        default:       tk = 0;
      endcase
      if (op == 1 && i_insn[5:3] == 3'd3)  m_carry = i_r1data[0];
      if (op == 10 && i_insn[5:4] == 2'd3) m_carry = i_r2data[0];
      if (i_we || op == 2) begin
        if ($signed(i_alu_result) < 0)  m_nzp = 3'b100;
        else if (i_alu_result == 0)     m_nzp = 3'b010;
        else                            m_nzp = 3'b001;
      end
      m_valid = 1; m_we = i_we; m_redir = tk;
      if (tk) m_tgt = i_alu_result[15:0];
      m_insn = i_insn; m_pc = i_pc; m_res = i_alu_result; m_wsel = i_wsel;
    end
  endfunction

  task automatic check_all();
    chk("valid", {31'b0, o_valid}, {31'b0, m_valid});
    chk("we", {31'b0, o_we}, {31'b0, m_we});
    chk("redirect", {31'b0, o_redirect}, {31'b0, m_redir});
    chk("nzp", {29'b0, o_nzp}, {29'b0, m_nzp});
    chk("carry", {31'b0, o_carry}, {31'b0, m_carry});
    if (m_valid) begin
      chk("insn", {16'b0, o_insn}, {16'b0, m_insn});
      chk("pc", {16'b0, o_pc}, {16'b0, m_pc});
      chk("result", {16'b0, o_result}, {16'b0, m_res});
      chk("wsel", {29'b0, o_wsel}, {29'b0, m_wsel});
    end
    if (m_redir) chk("target", {16'b0, o_target}, {16'b0, m_tgt});
  endtask

  // Drive one beat (called at a negedge), clock it, update model, check.
  task automatic step(input logic v, input logic [15:0] insn, input logic [W-1:0] res,
                      input logic we, input logic st, input logic fl,
                      input logic [W-1:0] r1 = '0, input logic [W-1:0] r2 = '0);
    i_valid = v; i_insn = insn; i_alu_result = res; i_we = we; i_stall = st; i_flush = fl;
    i_r1data = r1; i_r2data = r2; i_pc = 16'($urandom); i_wsel = 3'($urandom);
    #1 chk("ready", {31'b0, o_ready}, {31'b0, ~st});
    @(posedge clk);
    model_edge();
    #1 check_all();
    @(negedge clk);
  endtask

  logic [3:0] ops [11] = '{4'h0, 4'h0, 4'h2, 4'h1, 4'hA, 4'h4, 4'hC, 4'hF, 4'h8, 4'h5, 4'h6};

  initial begin
    logic [15:0] ri;
    rst_n = 0; i_valid = 0; i_insn = 0; i_pc = 0; i_alu_result = 0; i_r1data = 0;
    i_r2data = 0; i_wsel = 0; i_we = 0; i_stall = 0; i_flush = 0;
    model_reset();
    #12 rst_n = 1;
    @(negedge clk);
    check_all();
    chk("rst_target", {16'b0, o_target}, 32'h0);

    // ADD (N result) then BRn
    step(1, 16'h1000, 16'h8001, 1, 0, 0);
    chk("add_nzp", {29'b0, o_nzp}, 32'h4);
    step(1, 16'h0805, 16'h0040, 0, 0, 0);
    chk("brn_redir", {31'b0, o_redirect}, 32'h1);
    chk("brn_target", {16'b0, o_target}, 32'h0040);

    // Asynchronous reset mid-cycle with a pending redirect.
    #2 rst_n = 0;
    #1 model_reset();
    check_all();
    chk("arst_nzp", {29'b0, o_nzp}, 32'h2);
    chk("arst_redir", {31'b0, o_redirect}, 32'h0);
    @(negedge clk); rst_n = 1;

    // CMP zero, then BRnp (not taken), then BRz (taken)
    step(1, 16'h2000, 16'h0000, 0, 0, 0);
    chk("cmp_nzp", {29'b0, o_nzp}, 32'h2);
    step(1, 16'h0A03, 16'h1111, 0, 0, 0);
    chk("brnp_redir", {31'b0, o_redirect}, 32'h0);
    step(1, 16'h0403, 16'h2222, 0, 0, 0);
    chk("brz_redir", {31'b0, o_redirect}, 32'h1);
    chk("brz_target", {16'b0, o_target}, 32'h2222);

    // SDR1 seeds carry, SDR2 sees it, then reloads
    step(1, 16'h1018, 16'h0001, 1, 0, 0, 16'h0003, 16'h0);
    chk("sdr1_carry", {31'b0, o_carry}, 32'h1);
    i_insn = 16'hA030;
    #1 chk("sdr2_sees_carry", {31'b0, o_carry}, 32'h1);
    step(1, 16'hA030, 16'h8000, 1, 0, 0, 16'h0, 16'h0002);
    chk("sdr2_carry", {31'b0, o_carry}, 32'h0);

    // ADD accepted then 3 stalled beats presenting flag-changing instructions
    step(1, 16'h1000, 16'h1234, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, (k == 1) ? 16'h1018 : 16'h2000, 16'h8000, 1, 1, 0, 16'hFFFF, 16'hFFFF);
      chk("stall_result", {16'b0, o_result}, 32'h1234);
      chk("stall_valid", {31'b0, o_valid}, 32'h1);
      chk("stall_nzp", {29'b0, o_nzp}, 32'h1);
      chk("stall_carry", {31'b0, o_carry}, 32'h0);
    end

    // JMPR with stall+flush, then re-presented cleanly
    step(1, 16'hC1C0, 16'h0300, 1, 1, 1);
    chk("flush_valid", {31'b0, o_valid}, 32'h0);
    chk("flush_redir", {31'b0, o_redirect}, 32'h0);
    chk("flush_nzp", {29'b0, o_nzp}, 32'h1);
    step(1, 16'hC1C0, 16'h0300, 0, 0, 0);
    chk("jmpr_redir", {31'b0, o_redirect}, 32'h1);
    chk("jmpr_target", {16'b0, o_target}, 32'h0300);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      ri = 16'($urandom);
      ri[15:12] = ops[$urandom_range(0, 10)];
      if (ri[15:12] == 4'h1 && $urandom_range(0, 1) == 1) ri[5:3] = 3'd3;
      if (ri[15:12] == 4'hA && $urandom_range(0, 1) == 1) ri[5:4] = 2'd3;
      step($urandom_range(0, 5) != 0, ri,
           ($urandom_range(0, 3) == 0) ? '0 : W'($urandom),
           $urandom_range(0, 1) == 1, $urandom_range(0, 6) == 0,
           $urandom_range(0, 9) == 0, W'($urandom), W'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lc4_xm_stage.md
Name: lc4_xm_stage

Overview:
- Execute-to-memory pipeline register that sits directly downstream of the LC4 ALU.
- Captures the ALU result and its control fields, and maintains the architectural NZP flags.
- Maintains the multi-word shift carry flag and feeds it back to the ALU `carry` input for SDR2.
- Resolves branches, jumps and traps, and presents a registered redirect to fetch.

Parameters:
- WORD_SIZE, 16, datapath width of result/register data; NZP and carry are derived from it.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  ALU-stage instruction valid
- i_insn  in  16  instruction in execute
- i_pc  in  16  PC of that instruction
- i_alu_result  in  WORD_SIZE  ALU o_result
- i_r1data  in  WORD_SIZE  rs operand as seen by ALU
- i_r2data  in  WORD_SIZE  rt operand as seen by ALU
- i_wsel  in  3  destination register
- i_we  in  1  register write enable
- i_stall  in  1  downstream stall; hold everything
- i_flush  in  1  squash incoming instruction
- o_ready  out  1  = ~i_stall; upstream may advance
- o_carry  out  1  carry flag to ALU `carry` input
- o_valid  out  1  registered valid
- o_insn  out  16  registered instruction
- o_pc  out  16  registered PC
- o_result  out  WORD_SIZE  registered ALU result
- o_wsel  out  3  registered destination
- o_we  out  1  registered write enable (0 when o_valid=0)
- o_nzp  out  3  architectural NZP {N,Z,P}
- o_redirect  out  1  registered taken-control-transfer pulse
- o_target  out  16  registered redirect PC

Behaviour:
- Reset (async, rst_n=0): o_valid=0, o_we=0, o_redirect=0, o_insn=0, o_pc=0, o_result=0, o_wsel=0, o_target=0, o_carry=0, o_nzp=3'b010.
- Accept = i_valid & ~i_stall & ~i_flush. All state updates occur only on accept; latency is 1 cycle from accept to o_valid.
- Stall (i_stall=1, i_flush=0): every output and internal register holds. o_redirect holds its value and is not re-pulsed; fetch ignores o_redirect while stalled.
- Flush (i_flush=1): flush beats stall.
  - o_valid, o_we and o_redirect are set to 0 on the next edge.
  - NZP and carry are not updated.
  - Data registers may load but are don't-care.
- Cycles with i_valid=0 and no stall (bubble): o_valid=0, o_we=0, o_redirect=0; NZP and carry hold.
- NZP update on accept applies when i_we=1 or the opcode is CMP (i_insn[15:12]=0010):
  - N = i_alu_result[WORD_SIZE-1].
  - Z = (i_alu_result == 0).
  - P = ~N & ~Z.
  - Exactly one bit is set at all times.
- Carry update on accept:
  - SDR1 (i_insn[15:12]=0001, [5:3]=011): carry <= i_r1data[0].
  - SDR2 (i_insn[15:12]=1010, [5:4]=11): carry <= i_r2data[0]; the ALU consumes the old o_carry in the same cycle.
  - Otherwise carry holds.
- Branch resolution on accept is evaluated against the pre-update o_nzp, i.e. the state left by older instructions.
  - BR (i_insn[15:12]=0000): taken = |(i_insn[11:9] & o_nzp). NOP (i_insn[11:9]=000) is never taken.
  - JSR, JSRR, JMP, JMPR, TRAP, RTI (opcodes 0100, 1100, 1111, 1000): always taken.
  - o_redirect <= taken; o_target <= i_alu_result[15:0]. The ALU already supplies PC+1+imm, the register target, or the trap vector.
  - Not taken: o_redirect=0 and o_target holds.
- This stage does not gate write enables; JSR/JSRR/TRAP link writes arrive with i_we set by decode.
- A back-to-back CMP then BR resolves correctly because the BR sees the NZP committed on the CMP's accept edge.
- Reset asserted mid-stall or mid-redirect clears all registers immediately; no pending redirect survives.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> o_nzp=010, o_carry=0, o_valid=0 and o_redirect=0 without a clock edge.
- ADD with i_we=1, result 16'h8001, followed by BRn (insn 16'h0805), alu_result 16'h0040 -> after cycle 1 o_nzp=100; after cycle 2 o_redirect=1, o_target=16'h0040.
- CMP result 16'h0000 followed by BRnp (16'h0A03) -> o_nzp=010, o_redirect=0; then BRz (16'h0403) -> o_redirect=1.
- SDR1 with i_r1data=16'h0003, then SDR2 with i_r2data=16'h0002 -> o_carry=1 after SDR1 (the ALU sees carry=1 during SDR2); o_carry=0 after SDR2.
- ADD accepted, then i_stall=1 for 3 cycles -> o_result, o_valid=1 and o_nzp frozen; NZP and carry do not change from the instruction presented during the stall.
- JMPR with i_stall=1 and i_flush=1 together -> o_valid=0, o_redirect=0, NZP unchanged; the same JMPR re-presented without flush -> o_redirect=1, o_target=i_alu_result.
